fp32_mac_accumulator: RTL and testbench
=======================================

# fp32_mac_accumulator

Accumulates the stream of FP32 products leaving the neuron multiplier stage into one running FP32 sum per neuron. It accepts one term per handshake, performs a multi-cycle align/add/normalize, and emits the sum when the term flagged `last` has been folded in. The output feeds the neuron's activation stage. Arithmetic is simplified IEEE-754 single precision: truncation, denormals flushed to zero, no NaN/Inf propagation.

## Interface
- `COUNT_W`, default 16: width of the term counter.
- `clk_i` input 1: clock, rising edge.
- `reset_ni` input 1: synchronous, active-low reset.
- `in_valid_i` input 1: `in_data_i`/`in_last_i` valid.
- `in_ready_o` output 1: block can accept a term.
- `in_data_i` input 32: FP32 term (sign[31], exp[30:23], mant[22:0]).
- `in_last_i` input 1: final term of the current neuron.
- `sum_valid_o` output 1: `sum_o` holds a completed sum.
- `sum_ready_i` input 1: consumer takes the sum.
- `sum_o` output 32: accumulated FP32 sum.
- `count_o` output COUNT_W: terms accepted in the current accumulation; saturates at all-ones.
- `busy_o` output 1: state is not IDLE.

## Operation
- States are IDLE, ALIGN, ADD, NORM, OUT.
  - IDLE: `in_ready_o`=1. On `in_valid_i`, capture the term and `in_last_i`, increment the count, and go to ALIGN.
  - ALIGN: treat exp==0 operands as zero. Treat exp==255 operands as max finite with their sign. Order the accumulator and the term by magnitude so A≥B (exp, then mantissa). Shift B's 24-bit mantissa (hidden 1 included) right by expA−expB. A shift of ≥25 gives 0.
  - ADD: if the signs are equal, the 25-bit result is A+B. Otherwise it is A−B. Result sign = sign of A.
  - NORM:
    - Carry bit set: shift right 1 and increment the exponent.
    - Otherwise: left-shift by the leading-zero count of the 24-bit mantissa and subtract that count from the exponent.
    - Zero mantissa gives +0 (0x00000000).
    - Exponent ≥255 saturates to ±0x7F7FFFFF.
    - Exponent ≤0 flushes to +0.
    - Mantissa is truncated, never rounded.
    - Write the result to the accumulator. Go to OUT if the captured last flag is set, else to IDLE.
  - OUT: `sum_valid_o`=1 and `sum_o`=accumulator, held stable. On `sum_ready_i`, clear the accumulator to +0 and the count to 0, then go to IDLE.
- `in_ready_o` is 0 in every state except IDLE. Input is never accepted while busy or in OUT.
- A term with `in_last_i`=1 as the first term of a neuron is legal; the sum is that term, normalized.
- Illegal state encodings go to IDLE.

## Timing
- Reset (`reset_ni`=0 at an edge) sets state IDLE, accumulator 0x00000000, count 0, `sum_valid_o`=0, `sum_o`=0, `busy_o`=0, `in_ready_o`=1 after the edge. Reset overrides any state, including mid-ALIGN/ADD/NORM/OUT, and drops any in-flight term.
- Term accepted at edge T: ALIGN T..T+1, ADD T+1..T+2, NORM T+2..T+3. Back in IDLE with `in_ready_o`=1 after edge T+3. If last, `sum_valid_o`=1 after edge T+3.
- Maximum throughput: one term per 4 cycles.
- Output handshake completes on the edge where `sum_valid_o`&&`sum_ready_i`. `in_ready_o` rises the following cycle. `sum_ready_i` high early has no effect.
- `sum_o` outside OUT shows the accumulator's current value, which is don't-care for consumers.

## Structure
- Package `fp32_pkg` holds:
  - `fp32_t` packed struct (sign, exp[7:0], mant[22:0]);
  - `FP32_BIAS`=127;
  - `FP32_MAX_POS`=32'h7F7FFFFF and `FP32_ZERO`;
  - the accumulator `state_t` enum.
- One sub-module, `lzc24`: a combinational 24-bit leading-zero counter (5-bit output, 24 when input is zero), used in NORM.
- Registers: state, accumulator, captured term, last flag, aligned A/B mantissas + exponent + sign, 25-bit raw sum, count.

## Test plan
- 0x3F800000 (1.0) then 0x40000000 (2.0, last): expect `sum_o`=0x40400000 (3.0), `count_o`=2, `sum_valid_o` 4 cycles after the last accept.
- 0x3F800000 then 0xBF400000 (−0.75, last): expect 0x3E800000 (0.25), exercising a left-shift normalize by 2.
- 0x3FC00000 then 0xBFC00000 (last): expect exact cancellation to 0x00000000.
- 0x4B800000 (2^24) then 0x3F800000 (last): expect 0x4B800000 (truncation). Then 0x7F7FFFFF twice (last): expect saturation to 0x7F7FFFFF.
- Backpressure:
  - Complete a sum with `sum_ready_i` low for 5 cycles.
  - `sum_o`/`sum_valid_o` are held and `in_ready_o`=0 throughout.
  - After the handshake: `count_o`=0, and the next single-term neuron 0x40800000 (last) returns 0x40800000.
- Reset mid-operation: assert `reset_ni`=0 during ALIGN after accepting 0x40000000. Expect all outputs at reset values. The next neuron 0x3F800000 (last) returns 0x3F800000 with `count_o`=1.

Source files
------------

// File: rtl/fp32_pkg.sv
// FP32 types and constants shared by the MAC accumulator: truncating single precision,
// denormals flushed to zero, exp==255 treated as max finite.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam int          FP32_BIAS    = 127;
  localparam logic [31:0] FP32_MAX_POS = 32'h7F7FFFFF;
  localparam logic [31:0] FP32_ZERO    = 32'h00000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Magnitude key {exp, 24-bit mantissa}; ordering two keys orders the operands
  function automatic logic [31:0] fp32_operand(input fp32_t x);
    if (x.exp == 8'd0) return 32'd0;
    if (x.exp == 8'hFF) return {8'hFE, 24'hFFFFFF};
    return {x.exp, 1'b1, x.mant};
  endfunction

endpackage

// File: rtl/lzc24.sv
// Combinational leading-zero counter over 24 bits; returns 24 for an all-zero input.
module lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit write last and win
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp32_mac_accumulator.sv
// Per-neuron FP32 accumulator: one term per 4 cycles (align/add/normalize), sum valid 3 edges after the last accept;
// in_ready_o is low in every state but IDLE, and sum_o/sum_valid_o hold until sum_ready_i.
module fp32_mac_accumulator
  import fp32_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_data_i,
  input  logic               in_last_i,
  output logic               sum_valid_o,
  input  logic               sum_ready_i,
  output logic [31:0]        sum_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               busy_o
);

  state_t               state_q;
  fp32_t                acc_q;
  fp32_t                term_q;
  logic                 last_q;
  logic [23:0]          a_mant_q;
  logic [23:0]          b_mant_q;
  logic [7:0]           exp_q;
  logic                 sign_q;
  logic                 sub_q;
  logic [24:0]          sum_q;
  logic [COUNT_W-1:0]   count_q;

  logic [31:0] key_acc, key_trm, key_big, key_small;
  logic        big_sign, small_sign;
  logic [7:0]  shamt;
  logic [23:0] b_aligned;

  always_comb begin
    key_acc = fp32_operand(acc_q);
    key_trm = fp32_operand(term_q);
    if (key_acc >= key_trm) begin
      key_big    = key_acc;
      big_sign   = acc_q.sign;
      key_small  = key_trm;
      small_sign = term_q.sign;
    end else begin
      key_big    = key_trm;
      big_sign   = term_q.sign;
      key_small  = key_acc;
      small_sign = acc_q.sign;
    end
    shamt     = key_big[31:24] - key_small[31:24];
    b_aligned = (shamt >= 8'd25) ? 24'd0 : (key_small[23:0] >> shamt);
  end

  logic [4:0]        lz;
  logic signed [9:0] exp_n;
  logic [22:0]       mant_n;
  fp32_t             norm_res;

  lzc24 u_lzc (
    .value (sum_q[23:0]),
    .count (lz)
  );

  // Exponent is widened and signed so both overflow and underflow are visible
  always_comb begin
    if (sum_q[24]) begin
      mant_n = sum_q[23:1];
      exp_n  = $signed({2'b00, exp_q}) + 10'sd1;
    end else begin
      mant_n = 23'(sum_q[23:0] << lz);
      exp_n  = $signed({2'b00, exp_q}) - $signed({5'b00000, lz});
    end
    if (sum_q == '0)
      norm_res = FP32_ZERO;
    else if (exp_n >= 10'sd255)
      norm_res = {sign_q, FP32_MAX_POS[30:0]};
    else if (exp_n <= 10'sd0)
      norm_res = FP32_ZERO;
    else
      norm_res = {sign_q, exp_n[7:0], mant_n};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      acc_q    <= FP32_ZERO;
      term_q   <= FP32_ZERO;
      last_q   <= 1'b0;
      a_mant_q <= '0;
      b_mant_q <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      sum_q    <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            term_q  <= in_data_i;
            last_q  <= in_last_i;
            if (count_q != '1) count_q <= count_q + 1'b1;
            state_q <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          a_mant_q <= key_big[23:0];
          b_mant_q <= b_aligned;
          exp_q    <= key_big[31:24];
          sign_q   <= big_sign;
          sub_q    <= big_sign ^ small_sign;
          state_q  <= ST_ADD;
        end
        ST_ADD: begin
          sum_q   <= sub_q ? ({1'b0, a_mant_q} - {1'b0, b_mant_q})
                           : ({1'b0, a_mant_q} + {1'b0, b_mant_q});
          state_q <= ST_NORM;
        end
        ST_NORM: begin
          acc_q   <= norm_res;
          state_q <= last_q ? ST_OUT : ST_IDLE;
        end
        ST_OUT: begin
          if (sum_ready_i) begin
            acc_q   <= FP32_ZERO;
            count_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign sum_valid_o = (state_q == ST_OUT);
  assign sum_o       = acc_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_fp32_mac_accumulator.sv
// Directed and randomized checks of fp32_mac_accumulator against an integer-arithmetic reference.
module tb_fp32_mac_accumulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic [31:0] sum;
  logic [15:0] count;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] nq[$];

  always #5 clk = ~clk;

  fp32_mac_accumulator #(.COUNT_W(16)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .sum_valid_o (sum_valid),
    .sum_ready_i (sum_ready),
    .sum_o       (sum),
    .count_o     (count),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value of an operand as integer mantissa and exponent, with the block's zero/max rules
  function automatic void decode(input logic [31:0] x, output longint e, output longint m);
    e = longint'(x[30:23]);
    if (e == 0) begin
      m = 0;
    end else if (e == 255) begin
      e = 254;
      m = 16777215;
    end else begin
      m = 8388608 + longint'(x[22:0]);
    end
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] acc, input logic [31:0] t);
    longint ea, ma, eb, mb, tmp, d, bq, r, e;
    bit sa, sb, ts;
    decode(acc, ea, ma);
    decode(t, eb, mb);
    sa = acc[31];
    sb = t[31];
    if (eb * 16777216 + mb > ea * 16777216 + ma) begin
      tmp = ea; ea = eb; eb = tmp;
      tmp = ma; ma = mb; mb = tmp;
      ts = sa; sa = sb; sb = ts;
    end
    d  = ea - eb;
    bq = (d >= 25) ? 0 : mb / (longint'(1) << d);
    r  = (sa == sb) ? ma + bq : ma - bq;
    if (r == 0) return 32'h00000000;
    e = ea;
    while (r >= 16777216) begin r = r / 2; e++; end
    while (r < 8388608) begin r = r * 2; e--; end
    if (e >= 255) return {sa, 31'h7F7FFFFF};
    if (e <= 0) return 32'h00000000;
    return {sa, 8'(e), 23'(r - 8388608)};
  endfunction

  task automatic send_term(input logic [31:0] data, input logic last);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_neuron(input string tag, input int delay, input logic [31:0] want);
    int lat = 0;
    for (int i = 0; i < nq.size(); i++) send_term(nq[i], (i == nq.size() - 1));
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy"}, 32'({busy, in_ready}), 32'd2);
    end while (!sum_valid && lat < 20);
    check({tag, "_lat"}, lat, 32'd4);
    check({tag, "_sum"}, sum, want);
    check({tag, "_cnt"}, 32'(count), nq.size());
    // Offer a term while the sum is waiting; it must be ignored
    for (int d = 0; d < delay; d++) begin
      in_valid = 1'b1;
      in_data  = 32'h3F800000;
      in_last  = 1'b1;
      @(negedge clk);
      check({tag, "_hold_sum"}, sum, want);
      check({tag, "_hold_flags"}, 32'({sum_valid, in_ready}), 32'd2);
      check({tag, "_hold_cnt"}, 32'(count), nq.size());
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    sum_ready = 1'b1;
    @(posedge clk);
    #1 sum_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_cnt"}, 32'(count), 32'd0);
    check({tag, "_post_flags"}, 32'({sum_valid, in_ready, busy}), 32'd2);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sum"}, sum, 32'd0);
    check({tag, "_cnt"}, 32'(count), 32'd0);
    check({tag, "_flags"}, 32'({sum_valid, busy, in_ready}), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] t, prev, acc;
    int len, r, e;

    @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    #1 reset_n = 1'b1;

    nq = {32'h3F800000, 32'h40000000};
    run_neuron("one_plus_two", 0, 32'h40400000);
    nq = {32'h3F800000, 32'hBF400000};
    run_neuron("left_norm", 0, 32'h3E800000);
    nq = {32'h3FC00000, 32'hBFC00000};
    run_neuron("cancel", 0, 32'h00000000);
    nq = {32'h4B800000, 32'h3F800000};
    run_neuron("truncate", 0, 32'h4B800000);
    nq = {32'h7F7FFFFF, 32'h7F7FFFFF};
    run_neuron("saturate", 0, 32'h7F7FFFFF);

    nq = {32'h3F800000, 32'h40000000};
    run_neuron("backpressure", 5, 32'h40400000);
    nq = {32'h40800000};
    run_neuron("after_bp", 0, 32'h40800000);

    send_term(32'h40000000, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_state("mid_reset");
    nq = {32'h3F800000};
    run_neuron("after_reset", 0, 32'h3F800000);

    for (int n = 0; n < 25; n++) begin
      len  = $urandom_range(1, 4);
      nq   = {};
      acc  = 32'd0;
      prev = 32'd0;
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 15);
        if (r == 0) e = 0;
        else if (r == 1) e = 255;
        else if (r == 3) e = 1;
        else e = $urandom_range(110, 140);
        t = {1'($urandom), 8'(e), 23'($urandom)};
        if (r == 2 && i > 0) t = prev ^ 32'h80000001;
        nq.push_back(t);
        acc  = ref_add(acc, t);
        prev = acc;
      end
      run_neuron("random", $urandom_range(0, 3), acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
